// File: rtl/regfile16_1w2r.sv
`timescale 1ns/1ps
// regfile16_1w2r: 16-entry 1-write/2-read register file fed by one-hot decoder enables.
// Latency: write visible in array next cycle; reads registered, 1 cycle address-to-Q, with same-cycle write bypass.
// Backpressure: none; RE low holds QA/QB, writes always proceed, multi-hot enables are dropped and flagged.
//
// Ports:
//   Clock   - system clock, rising edge
//   Resetn  - asynchronous active-low reset
//   WE      - one-hot write enables (bit i -> entry i), zero = no write
//   WD      - write data
//   RA/RB   - read addresses, ports A/B
//   RE      - read enable for both ports
//   ERRCLR  - synchronous clear of ERR
//   QA/QB   - registered read data
//   ERR     - sticky multi-hot enable flag
//   WCNT    - accepted-write count, saturating at 31

module regfile16_1w2r #(
  parameter int DW = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [15:0]   WE,
  input  logic [DW-1:0] WD,
  input  logic [3:0]    RA,
  input  logic [3:0]    RB,
  input  logic          RE,
  input  logic          ERRCLR,
  output logic [DW-1:0] QA,
  output logic [DW-1:0] QB,
  output logic          ERR,
  output logic [4:0]    WCNT
);

  localparam int NENT = 16;
  localparam logic [4:0] WCNT_MAX = 5'd31;

  typedef enum logic {
    ST_OK    = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  logic [DW-1:0] mem [NENT];
  logic [DW-1:0] qa_q;
  logic [DW-1:0] qb_q;
  logic [4:0]    wcnt_q;
  state_t        state_q;
  state_t        state_d;

  // Enable classification. Clearing the lowest set bit leaves zero only
  // when exactly one bit was set.
  logic we_any;
  logic we_onehot;
  logic we_multi;

  always_comb begin
    we_any    = (WE != 16'd0);
    we_onehot = we_any && ((WE & (WE - 16'd1)) == 16'd0);
    we_multi  = we_any && !we_onehot;
  end

  // Read data selection. Only a valid one-hot write may be forwarded; a
  // corrupt multi-hot enable must never leak its data to the read ports.
  logic          byp_a;
  logic          byp_b;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;

  always_comb begin
    byp_a = we_onehot && WE[RA];
    byp_b = we_onehot && WE[RB];
    rd_a  = byp_a ? WD : mem[RA];
    rd_b  = byp_b ? WD : mem[RB];
  end

  // Storage array: each entry loads only on its own enable within a
  // one-hot write.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NENT; i++) begin
        mem[i] <= '0;
      end
    end else if (we_onehot) begin
      for (int i = 0; i < NENT; i++) begin
        if (WE[i]) begin
          mem[i] <= WD;
        end
      end
    end
  end

  // Registered read ports, held while RE is low.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      qa_q <= '0;
      qb_q <= '0;
    end else if (RE) begin
      qa_q <= rd_a;
      qb_q <= rd_b;
    end
  end

  // Accepted-write counter; sticks at its maximum rather than wrapping.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wcnt_q <= '0;
    end else if (we_onehot && (wcnt_q != WCNT_MAX)) begin
      wcnt_q <= wcnt_q + 5'd1;
    end
  end

  // Error-tracking FSM: state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_OK;
    end else begin
      state_q <= state_d;
    end
  end

  // Error-tracking FSM: next state. A multi-hot write in the same cycle as
  // ERRCLR keeps the fault, so an error is never silently lost.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OK: begin
        if (we_multi) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (ERRCLR && !we_multi) begin
          state_d = ST_OK;
        end
      end
      default: state_d = ST_OK;
    endcase
  end

  assign QA   = qa_q;
  assign QB   = qb_q;
  assign ERR  = (state_q == ST_FAULT);
  assign WCNT = wcnt_q;

endmodule
